// File: rtl/sort_vec_packer.sv
// Packs a serial valid/ready element stream into NUM_ELEMS-wide vectors for the sorter.
// Short frames (in_last) are padded with all-ones; an assembly and an output register decouple fill from drain.
module sort_vec_packer #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0] out_vec,
  output logic [$clog2(NUM_ELEMS+1)-1:0]  out_count,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam int CNT_W = $clog2(NUM_ELEMS+1);
  localparam int VEC_W = NUM_ELEMS*DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] PAD = {DATA_WIDTH{1'b1}};

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [VEC_W-1:0]   asm_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [VEC_W-1:0]   out_vec_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_valid_q;

  logic               accept, drain, out_free, complete;
  logic [VEC_W-1:0]   comp_vec;
  logic [CNT_W-1:0]   comp_cnt;
  logic               load_new, load_held, hold_new;

  // Ready is gated by rst_n so the upstream sees a stall for the whole reset window.
  assign in_ready  = rst_n && (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign complete  = accept && (in_last || (idx_q == IDX_W'(NUM_ELEMS-1)));
  assign comp_cnt  = CNT_W'(idx_q) + CNT_W'(1);

  // Slots below the index are already filled; slots above it hold stale data and must be padded.
  always_comb begin
    comp_vec = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (k < int'(idx_q))       comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = asm_q[k*DATA_WIDTH +: DATA_WIDTH];
      else if (k == int'(idx_q)) comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      else                       comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = PAD;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    load_new  = 1'b0;
    load_held = 1'b0;
    hold_new  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (complete) begin
          if (out_free) begin
            load_new = 1'b1;
          end else begin
            hold_new = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (drain) begin
          load_held = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      hold_cnt_q  <= '0;
      out_vec_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        if (complete) begin
          idx_q <= '0;
        end else begin
          for (int k = 0; k < NUM_ELEMS; k++)
            if (IDX_W'(k) == idx_q) asm_q[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          idx_q <= idx_q + IDX_W'(1);
        end
      end

      if (hold_new) begin
        asm_q      <= comp_vec;
        hold_cnt_q <= comp_cnt;
      end

      if (load_new) begin
        out_vec_q   <= comp_vec;
        out_count_q <= comp_cnt;
      end else if (load_held) begin
        out_vec_q   <= asm_q;
        out_count_q <= hold_cnt_q;
      end

      if (load_new || load_held) out_valid_q <= 1'b1;
      else if (drain)            out_valid_q <= 1'b0;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sort_vec_packer.sv
// Directed bench for sort_vec_packer: stimulus pushes expected vectors into a scoreboard,
// a negedge monitor pops and compares on each output handshake.
module tb_sort_vec_packer;

  logic        tb_clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [11:0] out_vec;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [11:0] vec;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sort_vec_packer #(.DATA_WIDTH(3), .NUM_ELEMS(4)) dut (
    .clk       (tb_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] vec, input logic [2:0] cnt);
    exp_t e;
    e.vec = vec;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Drives one element and returns #1 after the edge that accepted it; in_valid stays high.
  task automatic send(input logic [2:0] d, input logic l);
    int n;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge tb_clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  // Monitor: every output handshake must match the oldest expected vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge tb_clk);
      if (rst_n && out_valid && out_ready) begin
        check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_out_vec", {20'b0, out_vec}, {20'b0, e.vec});
          check("sb_out_count", {29'b0, out_count}, {29'b0, e.cnt});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_vec", {20'b0, out_vec}, 32'd0);
    check("rst_out_count", {29'b0, out_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge tb_clk);
    rst_n = 1'b1;
    @(posedge tb_clk);
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: full frame, latency 1, single-cycle valid
    push(12'h5CD, 3'd4);
    send(3'd5, 1'b0);
    send(3'd1, 1'b0);
    send(3'd7, 1'b0);
    check("t1_not_yet_valid", {31'b0, out_valid}, 32'd0);
    send(3'd2, 1'b0);
    check("t1_valid_after_4th", {31'b0, out_valid}, 32'd1);
    idle(1);
    check("t1_valid_one_cycle", {31'b0, out_valid}, 32'd0);

    // 2: early close with padding, next frame restarts at slot 0
    push(12'hFF3, 3'd2);
    send(3'd3, 1'b0);
    send(3'd6, 1'b1);
    idle(2);

    // 3: single element frame; in_last without in_valid has no effect
    push(12'hFF8, 3'd1);
    send(3'd0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b1;
    repeat (3) begin
      @(posedge tb_clk);
      #1;
      check("t3_last_no_valid", {31'b0, out_valid}, 32'd0);
    end
    push(12'hB1A, 3'd4);
    send(3'd2, 1'b0);
    send(3'd3, 1'b0);
    send(3'd4, 1'b0);
    send(3'd5, 1'b0);
    idle(2);

    // 4: backpressure fills both registers, then drains with no bubble
    out_ready = 1'b0;
    push(12'h688, 3'd4);
    push(12'hFAC, 3'd4);
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
    in_data = 3'd5;
    in_last = 1'b1;
    repeat (3) begin
      @(negedge tb_clk);
      check("t4_stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("t4_stable_vec", {20'b0, out_vec}, 32'h688);
      check("t4_stable_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge tb_clk);
    #1;
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    check("t4_no_bubble_valid", {31'b0, out_valid}, 32'd1);
    check("t4_second_vec", {20'b0, out_vec}, 32'hFAC);
    push(12'hFFD, 3'd1);
    send(3'd5, 1'b1);
    idle(2);

    // 5: drain and completion on the same edge
    out_ready = 1'b0;
    push(12'h5CD, 3'd4);
    send(3'd5, 1'b0);
    send(3'd1, 1'b0);
    send(3'd7, 1'b0);
    send(3'd2, 1'b0);
    send(3'd1, 1'b0);
    send(3'd1, 1'b0);
    send(3'd1, 1'b0);
    check("t5_holding", {20'b0, out_vec}, 32'h5CD);
    push(12'h249, 3'd4);
    out_ready = 1'b1;
    send(3'd1, 1'b0);
    check("t5_valid_kept", {31'b0, out_valid}, 32'd1);
    check("t5_new_vec", {20'b0, out_vec}, 32'h249);
    idle(2);
    check("t5_drained", {31'b0, out_valid}, 32'd0);

    // 6: reset mid-frame discards pending output and partial frame
    out_ready = 1'b0;
    send(3'd7, 1'b0);
    send(3'd7, 1'b0);
    send(3'd7, 1'b0);
    send(3'd7, 1'b0);
    send(3'd3, 1'b0);
    send(3'd3, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("t6_rst_vec", {20'b0, out_vec}, 32'd0);
    @(negedge tb_clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t6_release_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    push(12'h249, 3'd4);
    for (int i = 0; i < 4; i++) send(3'd1, 1'b0);
    idle(3);

    check("sb_empty_at_end", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
